lcd_text_engine: RTL and testbench

//  Parametrised HD44780 8-bit character-LCD driver for the Spartan-3AN kit: power-up init, then

---
 rtl/lcd_text_engine_if.sv | 12 +
 rtl/lcd_text_engine.sv | 187 ++++++++++++++++++
 tb/tb_lcd_text_engine.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_text_engine_if.sv
// rtl/lcd_text_engine_if.sv - host write port into the LCD text buffer
interface lcd_text_engine_if #(
    parameter int ADDR_W = 5
);
    logic              WR_VALID;
    logic              WR_READY;
    logic [ADDR_W-1:0] WR_ADDR;
    logic [7:0]        WR_CHAR;

    modport master (output WR_VALID, WR_ADDR, WR_CHAR, input WR_READY);
    modport slave  (input WR_VALID, WR_ADDR, WR_CHAR, output WR_READY);
endinterface

// File: rtl/lcd_text_engine.sv
// rtl/lcd_text_engine.sv - HD44780 8-bit text LCD driver with host-writable 2-line buffer
module lcd_text_engine #(
    parameter int          COLS         = 16,
    parameter int          ADDR_W       = 5,
    parameter int unsigned POWERUP_WAIT = 750000,
    parameter int unsigned INIT_WAIT_1  = 205000,
    parameter int unsigned INIT_WAIT_2  = 5000,
    parameter int unsigned E_PULSE      = 12,
    parameter int unsigned CMD_WAIT     = 2000,
    parameter int unsigned CLEAR_WAIT   = 82000,
    parameter int unsigned REFRESH_WAIT = 500000,
    parameter int unsigned SCROLL_HOLD  = 25000000
) (
    input  logic             CLOCK_50MHZ,
    input  logic             BUTTON_SOUTH,
    lcd_text_engine_if.slave wr,
    input  logic             SCROLL_EN,
    output logic             INIT_DONE,
    output logic [7:0]       LCD_DATA_BIT,
    output logic             LCD_ENABLE,
    output logic             LCD_REGISTER_SELECT,
    output logic             LCD_READ_WRITE
);
    typedef enum logic [3:0] {
        S_PWR, S_I1, S_I2, S_I3, S_FSET, S_ENTRY, S_DISP, S_CLR,
        S_L0ADDR, S_L0, S_L1ADDR, S_L1, S_SHIFT, S_HOME, S_IDLE
    } state_t;
    typedef enum logic {PH_PULSE, PH_WAIT} phase_t;

    localparam int                DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   BUF_LEN    = (ADDR_W + 1)'(2 * COLS);
    localparam logic [ADDR_W-1:0] LAST_COL   = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] LINE1_BASE = ADDR_W'(COLS);
    localparam logic [31:0]       E_LEN      = (E_PULSE == 0) ? 32'd1 : 32'(E_PULSE);

    state_t            st, st_n;
    phase_t            ph, ph_n;
    logic [31:0]       cnt, cnt_n;
    logic [ADDR_W-1:0] col, col_n, rd_idx;
    logic [7:0]        db_q, db_n;
    logic              rs_q, rs_n, e_q, e_n, done_q, done_n;
    logic              shifted, shifted_n, ready_q, advance;
    logic [7:0]        buf_mem [0:DEPTH-1];

    // Last counter value of the post-command wait for each state; a zero wait still lasts one cycle.
    function automatic logic [31:0] wait_last(input state_t s);
        int unsigned n;
        case (s)
            S_PWR:          n = POWERUP_WAIT;
            S_I1:           n = INIT_WAIT_1;
            S_I2:           n = INIT_WAIT_2;
            S_CLR, S_HOME:  n = CLEAR_WAIT;
            S_SHIFT:        n = SCROLL_HOLD;
            S_IDLE:         n = REFRESH_WAIT;
            default:        n = CMD_WAIT;
        endcase
        return (n == 0) ? 32'd0 : 32'(n - 1);
    endfunction

    always_ff @(posedge CLOCK_50MHZ or posedge BUTTON_SOUTH) begin
        if (BUTTON_SOUTH) begin
            st      <= S_PWR;
            ph      <= PH_WAIT;
            cnt     <= '0;
            col     <= '0;
            db_q    <= '0;
            rs_q    <= 1'b0;
            e_q     <= 1'b0;
            done_q  <= 1'b0;
            shifted <= 1'b0;
            ready_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) buf_mem[i] <= 8'h20;
        end else begin
            st      <= st_n;
            ph      <= ph_n;
            cnt     <= cnt_n;
            col     <= col_n;
            db_q    <= db_n;
            rs_q    <= rs_n;
            e_q     <= e_n;
            done_q  <= done_n;
            shifted <= shifted_n;
            ready_q <= 1'b1;
            if (wr.WR_VALID && ready_q && ({1'b0, wr.WR_ADDR} < BUF_LEN))
                buf_mem[wr.WR_ADDR] <= wr.WR_CHAR;
        end
    end

    always_comb begin
        st_n      = st;
        ph_n      = ph;
        cnt_n     = cnt + 32'd1;
        col_n     = col;
        db_n      = db_q;
        rs_n      = rs_q;
        e_n       = e_q;
        done_n    = done_q;
        shifted_n = shifted;
        advance   = 1'b0;
        rd_idx    = '0;

        if (ph == PH_PULSE) begin
            e_n = 1'b1;
            if (cnt == E_LEN) begin
                e_n   = 1'b0;
                ph_n  = PH_WAIT;
                cnt_n = '0;
            end
        end else if (cnt == wait_last(st)) begin
            advance = 1'b1;
        end

        if (advance) begin
            cnt_n = '0;
            ph_n  = PH_PULSE;
            unique case (st)
                S_PWR:    st_n = S_I1;
                S_I1:     st_n = S_I2;
                S_I2:     st_n = S_I3;
                S_I3:     st_n = S_FSET;
                S_FSET:   st_n = S_ENTRY;
                S_ENTRY:  st_n = S_DISP;
                S_DISP:   st_n = S_CLR;
                S_CLR: begin
                    st_n   = S_L0ADDR;
                    done_n = 1'b1;
                end
                S_L0ADDR: begin
                    st_n  = S_L0;
                    col_n = '0;
                end
                S_L0: begin
                    if (col == LAST_COL) st_n = S_L1ADDR;
                    else                 col_n = col + 1'b1;
                end
                S_L1ADDR: begin
                    st_n  = S_L1;
                    col_n = '0;
                end
                S_L1: begin
                    if (col != LAST_COL) begin
                        col_n = col + 1'b1;
                    end else if (SCROLL_EN) begin
                        st_n      = S_SHIFT;
                        shifted_n = 1'b1;
                    end else if (shifted) begin
                        st_n      = S_HOME;
                        shifted_n = 1'b0;
                    end else begin
                        st_n = S_IDLE;
                        ph_n = PH_WAIT;
                    end
                end
                S_HOME: begin
                    st_n = S_IDLE;
                    ph_n = PH_WAIT;
                end
                default:  st_n = S_L0ADDR;
            endcase

            // RS/DB are latched only on the edge that starts a new byte.
            if (ph_n == PH_PULSE) begin
                rd_idx = (st_n == S_L1) ? (col_n + LINE1_BASE) : col_n;
                rs_n   = (st_n == S_L0) || (st_n == S_L1);
                case (st_n)
                    S_I1, S_I2, S_I3, S_FSET: db_n = 8'h38;
                    S_ENTRY:                  db_n = 8'h06;
                    S_DISP:                   db_n = 8'h0C;
                    S_CLR:                    db_n = 8'h01;
                    S_L0ADDR:                 db_n = 8'h80;
                    S_L1ADDR:                 db_n = 8'hC0;
                    S_SHIFT:                  db_n = 8'h18;
                    S_HOME:                   db_n = 8'h02;
                    S_L0, S_L1:               db_n = buf_mem[rd_idx];
                    default:                  db_n = db_q;
                endcase
            end
        end
    end

    assign wr.WR_READY           = ready_q;
    assign INIT_DONE             = done_q;
    assign LCD_DATA_BIT          = db_q;
    assign LCD_ENABLE            = e_q;
    assign LCD_REGISTER_SELECT   = rs_q;
    assign LCD_READ_WRITE        = 1'b0;
endmodule

// File: tb/tb_lcd_text_engine.sv
// tb/tb_lcd_text_engine.sv - self-checking bench for lcd_text_engine against a command-timeline model
module tb_lcd_text_engine;
    localparam int COLS = 4, ADDR_W = 4;
    localparam int PW = 20, IW1 = 9, IW2 = 5, EP = 3, CW = 2, CLW = 7, RFW = 6, SH = 11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scroll_en = 1'b0;
    logic       init_done, lcd_e, lcd_rs, lcd_rw;
    logic [7:0] lcd_db;

    lcd_text_engine_if #(.ADDR_W(ADDR_W)) wr_bus();

    lcd_text_engine #(
        .COLS(COLS), .ADDR_W(ADDR_W), .POWERUP_WAIT(PW), .INIT_WAIT_1(IW1), .INIT_WAIT_2(IW2),
        .E_PULSE(EP), .CMD_WAIT(CW), .CLEAR_WAIT(CLW), .REFRESH_WAIT(RFW), .SCROLL_HOLD(SH)
    ) dut (
        .CLOCK_50MHZ(clk), .BUTTON_SOUTH(rst), .wr(wr_bus), .SCROLL_EN(scroll_en),
        .INIT_DONE(init_done), .LCD_DATA_BIT(lcd_db), .LCD_ENABLE(lcd_e),
        .LCD_REGISTER_SELECT(lcd_rs), .LCD_READ_WRITE(lcd_rw)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Expected display traffic: a queue of commands/waits refilled one pass at a time.
    typedef struct {bit is_wait; bit is_data; bit rs; int addr; logic [7:0] val; int n; bit set_done;} item_t;
    typedef struct {logic rs; logic [7:0] db; int cyc;} ev_t;

    item_t      q[$];
    item_t      cur;
    ev_t        evs[$];
    int         pos, total, done_cyc;
    logic [7:0] m_buf [0:2*COLS-1];
    bit         m_shifted, m_need_decide;
    logic       m_e, m_rs, m_done, m_ready;
    logic [7:0] m_db;
    logic       e_prev, done_prev;

    int init_db[7]   = '{'h038, 'h038, 'h038, 'h038, 'h006, 'h00C, 'h001};
    int init_rise[7] = '{21, 34, 43, 49, 55, 61, 67};
    int blank[10]    = '{'h080, 'h120, 'h120, 'h120, 'h120, 'h0C0, 'h120, 'h120, 'h120, 'h120};
    int text[10]     = '{'h080, 'h141, 'h142, 'h143, 'h144, 'h0C0, 'h177, 'h178, 'h179, 'h17A};
    int wa[9]        = '{3, 0, 1, 2, 3, 4, 5, 6, 7};
    int wc[9]        = '{'h58, 'h41, 'h42, 'h43, 'h44, 'h77, 'h78, 'h79, 'h7A};

    function automatic int eff(input int n);
        return (n == 0) ? 1 : n;
    endfunction

    function automatic item_t mk_cmd(input logic [7:0] v, input int n);
        item_t it;
        it = '{is_wait: 0, is_data: 0, rs: 0, addr: 0, val: v, n: n, set_done: 0};
        return it;
    endfunction

    function automatic item_t mk_wait(input int n);
        item_t it;
        it = '{is_wait: 1, is_data: 0, rs: 0, addr: 0, val: 8'h00, n: n, set_done: 0};
        return it;
    endfunction

    function automatic item_t mk_data(input int a);
        item_t it;
        it = '{is_wait: 0, is_data: 1, rs: 1, addr: a, val: 8'h00, n: CW, set_done: 0};
        return it;
    endfunction

    task automatic model_reset();
        q.delete();
        cur = mk_wait(PW);
        total = eff(PW);
        pos = 0;
        q.push_back(mk_cmd(8'h38, IW1));
        q.push_back(mk_cmd(8'h38, IW2));
        q.push_back(mk_cmd(8'h38, CW));
        q.push_back(mk_cmd(8'h38, CW));
        q.push_back(mk_cmd(8'h06, CW));
        q.push_back(mk_cmd(8'h0C, CW));
        q.push_back(mk_cmd(8'h01, CLW));
        for (int i = 0; i < 2 * COLS; i++) m_buf[i] = 8'h20;
        m_shifted = 0; m_need_decide = 0;
        m_e = 0; m_rs = 0; m_db = 8'h00; m_done = 0; m_ready = 0;
        cyc = 0;
    endtask

    task automatic start_next();
        item_t it;
        if (q.size() == 0) begin
            if (m_need_decide) begin
                m_need_decide = 0;
                if (scroll_en) begin
                    q.push_back(mk_cmd(8'h18, SH));
                    m_shifted = 1;
                end else if (m_shifted) begin
                    q.push_back(mk_cmd(8'h02, CLW));
                    q.push_back(mk_wait(RFW));
                    m_shifted = 0;
                end else begin
                    q.push_back(mk_wait(RFW));
                end
            end else begin
                it = mk_cmd(8'h80, CW);
                it.set_done = 1;
                q.push_back(it);
                for (int i = 0; i < COLS; i++) q.push_back(mk_data(i));
                q.push_back(mk_cmd(8'hC0, CW));
                for (int i = COLS; i < 2 * COLS; i++) q.push_back(mk_data(i));
                m_need_decide = 1;
            end
        end
        cur = q.pop_front();
        if (cur.is_data) cur.val = m_buf[cur.addr];
        total = cur.is_wait ? eff(cur.n) : 1 + eff(EP) + eff(cur.n);
        pos = 0;
        if (cur.set_done) m_done = 1;
        if (!cur.is_wait) begin
            m_db = cur.val;
            m_rs = cur.rs;
        end
    endtask

    task automatic model_step();
        int a;
        cyc++;
        pos++;
        if (pos >= total) start_next();
        m_e = !cur.is_wait && (pos >= 1) && (pos <= eff(EP));
        a = int'(wr_bus.WR_ADDR);
        if (wr_bus.WR_VALID && m_ready && a < 2 * COLS) m_buf[a] = wr_bus.WR_CHAR;
        m_ready = 1;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    initial begin
        ev_t ev;
        e_prev = 0;
        done_prev = 0;
        forever begin
            @(negedge clk);
            checks++;
            if ({lcd_e, lcd_rs, lcd_db, init_done, wr_bus.WR_READY, lcd_rw} !==
                {m_e, m_rs, m_db, m_done, m_ready, 1'b0}) begin
                errors++;
                $display("FAIL cycle_cmp cyc=%0d got e=%b rs=%b db=%h done=%b rdy=%b rw=%b want e=%b rs=%b db=%h done=%b rdy=%b rw=0",
                         cyc, lcd_e, lcd_rs, lcd_db, init_done, wr_bus.WR_READY, lcd_rw,
                         m_e, m_rs, m_db, m_done, m_ready);
            end
            if (lcd_e && !e_prev) begin
                ev.rs = lcd_rs; ev.db = lcd_db; ev.cyc = cyc;
                evs.push_back(ev);
            end
            if (init_done && !done_prev) done_cyc = cyc;
            e_prev = lcd_e;
            done_prev = init_done;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int ev_code(input int k);
        if (k < evs.size()) return (evs[k].rs ? 256 : 0) + int'(evs[k].db);
        return -1;
    endfunction

    function automatic int ev_cyc(input int k);
        if (k < evs.size()) return evs[k].cyc;
        return -1;
    endfunction

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic check_init_and_pass(input string tag, input bit use_text);
        for (int k = 0; k < 7; k++) chk({tag, "_init_cmd"}, ev_code(k), init_db[k]);
        for (int k = 0; k < 10; k++) chk({tag, "_pass1"}, ev_code(7 + k), use_text ? text[k] : blank[k]);
    endtask

    initial begin
        int n18, n02;
        wr_bus.WR_VALID = 1'b0;
        wr_bus.WR_ADDR  = '0;
        wr_bus.WR_CHAR  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_e", int'(lcd_e), 0);
        chk("rst_db", int'(lcd_db), 0);
        chk("rst_ready", int'(wr_bus.WR_READY), 0);
        rst = 1'b0;
        evs.delete();

        // Out-of-range write: accepted at once, nothing displayed changes.
        wait_cyc(100);
        chk("oor_ready", int'(wr_bus.WR_READY), 1);
        wr_bus.WR_VALID = 1'b1; wr_bus.WR_ADDR = 4'd8; wr_bus.WR_CHAR = 8'h55;
        @(negedge clk);
        wr_bus.WR_VALID = 1'b0;

        // Write address 1 on the very edge pass 2 latches it.
        wait_cyc(154);
        wr_bus.WR_VALID = 1'b1; wr_bus.WR_ADDR = 4'd1; wr_bus.WR_CHAR = 8'h51;
        @(negedge clk);
        wr_bus.WR_VALID = 1'b0;

        wait_cyc(210);
        scroll_en = 1'b1;
        wait_cyc(350);
        scroll_en = 1'b0;
        wait_cyc(540);

        check_init_and_pass("a", 1'b0);
        for (int k = 0; k < 7; k++) chk("init_rise_cyc", ev_cyc(k), init_rise[k]);
        chk("init_done_cyc", done_cyc, 77);
        chk("same_edge_old", ev_code(19), 'h120);
        chk("next_pass_new", ev_code(29), 'h151);
        chk("shift_cmd", ev_code(37), 'h018);
        chk("home_cmd", ev_code(59), 'h002);
        n18 = 0; n02 = 0;
        foreach (evs[k]) begin
            if (!evs[k].rs && evs[k].db == 8'h18) n18++;
            if (!evs[k].rs && evs[k].db == 8'h02) n02++;
        end
        chk("shift_count", n18, 2);
        chk("home_count", n02, 1);
        chk("mid_l1_e", int'(lcd_e), 1);

        // Reset while E is high in line 1.
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_e", int'(lcd_e), 0);
        chk("rst_mid_rs", int'(lcd_rs), 0);
        chk("rst_mid_db", int'(lcd_db), 0);
        chk("rst_mid_done", int'(init_done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        evs.delete();
        for (int i = 0; i < 9; i++) begin
            wr_bus.WR_VALID = 1'b1;
            wr_bus.WR_ADDR  = ADDR_W'(wa[i]);
            wr_bus.WR_CHAR  = 8'(wc[i]);
            @(negedge clk);
        end
        wr_bus.WR_VALID = 1'b0;
        wait_cyc(140);
        check_init_and_pass("e", 1'b1);

        // Reset again with no writes: buffer must be back to spaces.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        evs.delete();
        wait_cyc(140);
        check_init_and_pass("f", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
